// File: rtl/arp_pkg.sv
// Shared ARP definitions: protocol constants, the arphdr layout and
// helpers that move it between wire byte order and the packed struct.
package arp_pkg;

  localparam logic [15:0] ETH_P_ARP     = 16'h0806;
  localparam logic [15:0] ARPHRD_ETHER  = 16'd1;
  localparam logic [15:0] ETH_P_IP      = 16'h0800;
  localparam logic [15:0] ARPOP_REQUEST = 16'd1;
  localparam logic [15:0] ARPOP_REPLY   = 16'd2;

  localparam int ARP_FRAME_BYTES = 42;
  localparam int ARP_TX_BYTES    = 60;
  localparam int ARP_HDR_W       = ARP_FRAME_BYTES * 8;
  localparam int ARP_TX_W        = ARP_TX_BYTES * 8;
  localparam int TX_BEATS        = 8;
  localparam int ARP_IMG_W       = TX_BEATS * 64;

  localparam logic [2:0] RX_MAX_BEAT  = 3'd6;
  localparam logic [2:0] TX_LAST_BEAT = 3'd7;
  localparam logic [7:0] TX_LAST_KEEP = 8'h0F;

  typedef struct packed {
    logic [47:0] h_dest;
    logic [47:0] h_source;
    logic [15:0] h_proto;
    logic [15:0] ar_hrd;
    logic [15:0] ar_pro;
    logic [7:0]  ar_hln;
    logic [7:0]  ar_pln;
    logic [15:0] ar_op;
    logic [47:0] sender_mac;
    logic [31:0] sender_ip;
    logic [47:0] target_mac;
    logic [31:0] target_ip;
  } arphdr_t;

  // Wire order: byte i sits at bits [8*i +: 8], same as AXIS tdata lanes.
  typedef logic [ARP_HDR_W-1:0] arp_wire_t;

  typedef enum logic {RX_IDLE = 1'b0, RX_CAPTURE = 1'b1} rx_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_t;

  // Wire byte 0 becomes the most significant byte of the struct.
  function automatic arphdr_t wire_to_hdr(input arp_wire_t w);
    logic [ARP_HDR_W-1:0] v;
    for (int i = 0; i < ARP_FRAME_BYTES; i++) begin
      v[ARP_HDR_W-1-8*i -: 8] = w[8*i +: 8];
    end
    return arphdr_t'(v);
  endfunction

  function automatic arp_wire_t hdr_to_wire(input arphdr_t h);
    logic [ARP_HDR_W-1:0] v;
    arp_wire_t            w;
    v = h;
    for (int i = 0; i < ARP_FRAME_BYTES; i++) begin
      w[8*i +: 8] = v[ARP_HDR_W-1-8*i -: 8];
    end
    return w;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/arp_reply_tx.sv
// Holds one 60-byte ARP reply image and streams it onto the MAC TX
// AXI-Stream as eight 64-bit beats, the last one carrying four bytes.
module arp_reply_tx
  import arp_pkg::*;
(
  input  logic                clk156,
  input  logic                sys_rst_n,
  input  logic                load,
  input  logic [ARP_TX_W-1:0] reply_img,
  output logic                busy,
  output logic                tx_tvalid,
  input  logic                tx_tready,
  output logic [63:0]         tx_tdata,
  output logic [7:0]          tx_tkeep,
  output logic                tx_tlast
);

  tx_state_t            state_reg;
  logic [2:0]           beat_reg;
  logic [2:0]           beat_next;
  logic [ARP_IMG_W-1:0] image_reg;

  assign busy      = (state_reg != TX_IDLE);
  assign beat_next = beat_reg + 3'd1;

  // Outputs are registered and only move on a handshake, so they stay
  // stable for as long as the MAC holds tx_tready low.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= TX_IDLE;
      beat_reg  <= 3'd0;
      image_reg <= '0;
      tx_tvalid <= 1'b0;
      tx_tdata  <= '0;
      tx_tkeep  <= '0;
      tx_tlast  <= 1'b0;
    end else begin
      case (state_reg)
        TX_IDLE: begin
          if (load) begin
            image_reg <= {{(ARP_IMG_W-ARP_TX_W){1'b0}}, reply_img};
            state_reg <= TX_SEND;
            beat_reg  <= 3'd0;
            tx_tvalid <= 1'b1;
            tx_tdata  <= reply_img[63:0];
            tx_tkeep  <= 8'hFF;
            tx_tlast  <= 1'b0;
          end
        end
        TX_SEND: begin
          if (tx_tready) begin
            if (beat_reg == TX_LAST_BEAT) begin
              state_reg <= TX_IDLE;
              beat_reg  <= 3'd0;
              tx_tvalid <= 1'b0;
              tx_tdata  <= '0;
              tx_tkeep  <= '0;
              tx_tlast  <= 1'b0;
            end else begin
              beat_reg <= beat_next;
              tx_tdata <= image_reg[{beat_next, 6'd0} +: 64];
              tx_tkeep <= (beat_next == TX_LAST_BEAT) ? TX_LAST_KEEP : 8'hFF;
              tx_tlast <= (beat_next == TX_LAST_BEAT);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/arp_responder.sv
// Receive-side ARP responder: captures the first 42 bytes of each RX frame,
// qualifies ARP requests for local_ip on tlast and launches a padded reply.
module arp_responder
  import arp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk156,
  input  logic             sys_rst_n,
  input  logic [47:0]      local_mac,
  input  logic [31:0]      local_ip,
  input  logic             rx_tvalid,
  output logic             rx_tready,
  input  logic [63:0]      rx_tdata,
  input  logic [7:0]       rx_tkeep,
  input  logic             rx_tlast,
  input  logic             rx_tuser,
  output logic             tx_tvalid,
  input  logic             tx_tready,
  output logic [63:0]      tx_tdata,
  output logic [7:0]       tx_tkeep,
  output logic             tx_tlast,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  rx_state_t           rx_state_reg;
  logic [2:0]          beat_reg;
  logic [2:0]          beat_idx;
  arp_wire_t           cap_reg;
  arp_wire_t           cap_next;
  logic                rx_ready_reg;
  logic                rx_fire;
  arphdr_t             req_hdr;
  arphdr_t             reply_hdr;
  logic [ARP_TX_W-1:0] reply_img;
  logic                len_ok;
  logic                hdr_ok;
  logic                qualified;
  logic                tx_busy;
  logic                tx_load;
  logic [CNT_W-1:0]    req_cnt_reg;
  logic [CNT_W-1:0]    drop_cnt_reg;
  logic                unused_fields;

  assign rx_tready = rx_ready_reg;
  assign req_cnt   = req_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign rx_fire   = rx_tvalid && rx_ready_reg;
  assign beat_idx  = (rx_state_reg == RX_IDLE) ? 3'd0 : beat_reg;

  // The current beat is merged in combinationally so the tlast beat can be
  // qualified in the same cycle it arrives.
  generate
    for (genvar gi = 0; gi < ARP_FRAME_BYTES; gi++) begin : g_cap
      assign cap_next[gi*8 +: 8] = (rx_fire && beat_idx == 3'(gi / 8))
                                   ? rx_tdata[(gi % 8)*8 +: 8]
                                   : cap_reg[gi*8 +: 8];
    end
  endgenerate

  assign req_hdr = wire_to_hdr(cap_next);

  // At least 42 bytes: tlast on beat 6 or later, or on beat 5 with >=2 bytes.
  assign len_ok = (beat_idx >= RX_MAX_BEAT) ||
                  ((beat_idx == RX_MAX_BEAT - 3'd1) && (popcount8(rx_tkeep) >= 4'd2));

  assign hdr_ok = (req_hdr.h_proto == ETH_P_ARP) &&
                  (req_hdr.ar_hrd == ARPHRD_ETHER) &&
                  (req_hdr.ar_pro == ETH_P_IP) &&
                  (req_hdr.ar_hln == 8'd6) &&
                  (req_hdr.ar_pln == 8'd4) &&
                  (req_hdr.ar_op == ARPOP_REQUEST) &&
                  (req_hdr.target_ip == local_ip);

  assign qualified = rx_fire && rx_tlast && !rx_tuser && len_ok && hdr_ok;
  assign tx_load   = qualified && !tx_busy;

  // Header fields the responder never needs to inspect.
  assign unused_fields = ^{req_hdr.h_dest, req_hdr.h_source, req_hdr.target_mac};

  always_comb begin
    reply_hdr            = '0;
    reply_hdr.h_dest     = req_hdr.sender_mac;
    reply_hdr.h_source   = local_mac;
    reply_hdr.h_proto    = ETH_P_ARP;
    reply_hdr.ar_hrd     = ARPHRD_ETHER;
    reply_hdr.ar_pro     = ETH_P_IP;
    reply_hdr.ar_hln     = 8'd6;
    reply_hdr.ar_pln     = 8'd4;
    reply_hdr.ar_op      = ARPOP_REPLY;
    reply_hdr.sender_mac = local_mac;
    reply_hdr.sender_ip  = local_ip;
    reply_hdr.target_mac = req_hdr.sender_mac;
    reply_hdr.target_ip  = req_hdr.sender_ip;
  end

  assign reply_img = {{(ARP_TX_W-ARP_HDR_W){1'b0}}, hdr_to_wire(reply_hdr)};

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_ready_reg <= 1'b0;
      rx_state_reg <= RX_IDLE;
      beat_reg     <= 3'd0;
      cap_reg      <= '0;
      req_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      rx_ready_reg <= 1'b1;
      cap_reg      <= cap_next;
      if (rx_fire) begin
        if (rx_tlast) begin
          rx_state_reg <= RX_IDLE;
          beat_reg     <= 3'd0;
        end else begin
          rx_state_reg <= RX_CAPTURE;
          if (beat_idx != RX_MAX_BEAT) begin
            beat_reg <= beat_idx + 3'd1;
          end
        end
      end
      if (qualified) begin
        req_cnt_reg <= req_cnt_reg + CNT_W'(1);
        if (tx_busy) begin
          drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  arp_reply_tx u_reply_tx (
    .clk156    (clk156),
    .sys_rst_n (sys_rst_n),
    .load      (tx_load),
    .reply_img (reply_img),
    .busy      (tx_busy),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .tx_tdata  (tx_tdata),
    .tx_tkeep  (tx_tkeep),
    .tx_tlast  (tx_tlast)
  );

endmodule

// File: tb/tb_arp_responder.sv
// Self-checking bench for arp_responder: requests are built byte by byte,
// replies are predicted from the protocol rules and compared beat by beat.
module tb_arp_responder;

  localparam int          CNT_W = 16;
  localparam logic [47:0] LMAC  = 48'h001122334455;
  localparam logic [31:0] LIP   = 32'hc0a80a01;

  logic             clk156    = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [47:0]      local_mac = LMAC;
  logic [31:0]      local_ip  = LIP;
  logic             rx_tvalid = 1'b0;
  logic             rx_tready;
  logic [63:0]      rx_tdata  = '0;
  logic [7:0]       rx_tkeep  = '0;
  logic             rx_tlast  = 1'b0;
  logic             rx_tuser  = 1'b0;
  logic             tx_tvalid;
  logic             tx_tready = 1'b1;
  logic [63:0]      tx_tdata;
  logic [7:0]       tx_tkeep;
  logic             tx_tlast;
  logic [CNT_W-1:0] req_cnt;
  logic [CNT_W-1:0] drop_cnt;

  int total = 0;
  int bad = 0;
  int exp_req = 0;
  int exp_drop = 0;

  logic [7:0]  fr [0:79];
  int          fr_len;
  logic [7:0]  exp_b [0:63];
  logic [63:0] q_data [$];
  logic [7:0]  q_keep [$];
  logic        q_last [$];
  logic        hold_v = 1'b0;
  logic [72:0] hold_beat = '0;
  int          unstable = 0;

  arp_responder #(.CNT_W(CNT_W)) dut (
    .clk156(clk156), .sys_rst_n(sys_rst_n), .local_mac(local_mac), .local_ip(local_ip),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast),
    .req_cnt(req_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk156 = ~clk156;

  // Mid-cycle monitor: records each beat that will hand over on the next
  // edge and counts any change of a beat that is being held.
  always @(negedge clk156) begin
    if (hold_v && sys_rst_n && (!tx_tvalid || {tx_tdata, tx_tkeep, tx_tlast} !== hold_beat))
      unstable <= unstable + 1;
    hold_v    <= sys_rst_n && tx_tvalid && !tx_tready;
    hold_beat <= {tx_tdata, tx_tkeep, tx_tlast};
    if (sys_rst_n && tx_tvalid && tx_tready) begin
      q_data.push_back(tx_tdata);
      q_keep.push_back(tx_tkeep);
      q_last.push_back(tx_tlast);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk156);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_keep.delete();
    q_last.delete();
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 300 && q_data.size() < n; i++) tick(1);
  endtask

  task automatic put_be(input bit to_exp, input int off, input logic [47:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (to_exp) exp_b[off+i] = v[8*(n-1-i) +: 8];
      else        fr[off+i]    = v[8*(n-1-i) +: 8];
    end
  endtask

  task automatic make_req(input logic [47:0] smac, input logic [31:0] sip, input logic [31:0] tip,
                          input logic [15:0] op, input logic [15:0] proto, input int len);
    for (int i = 0; i < 80; i++) fr[i] = 8'($urandom);
    put_be(1'b0, 0, 48'hffffffffffff, 6);
    put_be(1'b0, 6, smac, 6);
    put_be(1'b0, 12, 48'(proto), 2);
    put_be(1'b0, 14, 48'h0001, 2);
    put_be(1'b0, 16, 48'h0800, 2);
    put_be(1'b0, 18, 48'h0604, 2);
    put_be(1'b0, 20, 48'(op), 2);
    put_be(1'b0, 22, smac, 6);
    put_be(1'b0, 28, 48'(sip), 4);
    put_be(1'b0, 32, 48'h0, 6);
    put_be(1'b0, 38, 48'(tip), 4);
    fr_len = len;
  endtask

  task automatic build_reply(input logic [47:0] smac, input logic [31:0] sip);
    for (int i = 0; i < 64; i++) exp_b[i] = 8'h00;
    put_be(1'b1, 0, smac, 6);
    put_be(1'b1, 6, LMAC, 6);
    put_be(1'b1, 12, 48'h0806, 2);
    put_be(1'b1, 14, 48'h0001, 2);
    put_be(1'b1, 16, 48'h0800, 2);
    put_be(1'b1, 18, 48'h0604, 2);
    put_be(1'b1, 20, 48'h0002, 2);
    put_be(1'b1, 22, LMAC, 6);
    put_be(1'b1, 28, 48'(LIP), 4);
    put_be(1'b1, 32, smac, 6);
    put_be(1'b1, 38, 48'(sip), 4);
  endtask

  function automatic logic [63:0] exp_word(input int k);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = exp_b[8*k+i];
    return w;
  endfunction

  function automatic logic [7:0] exp_keep(input int k);
    return (k == 7) ? 8'h0F : 8'hFF;
  endfunction

  task automatic send_frame(input bit bad_fcs);
    int nb;
    nb = (fr_len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 8; i++) begin
        rx_tdata[8*i +: 8] = fr[b*8+i];
        rx_tkeep[i]        = (b*8 + i < fr_len);
      end
      rx_tlast  = (b == nb - 1);
      rx_tuser  = bad_fcs && rx_tlast;
      rx_tvalid = 1'b1;
      tick(1);
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
    rx_tkeep  = '0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tx_tready = 1'b1;
    tick(3);
    total++; if (rx_tready !== 1'b0) begin bad++; $display("FAIL reset rx_tready got=%b exp=0", rx_tready); end
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL reset tx_tvalid got=%b exp=0", tx_tvalid); end
    total++; if (tx_tdata !== 64'h0) begin bad++; $display("FAIL reset tx_tdata got=%h exp=0", tx_tdata); end
    total++; if (tx_tkeep !== 8'h0) begin bad++; $display("FAIL reset tx_tkeep got=%h exp=0", tx_tkeep); end
    total++; if (tx_tlast !== 1'b0) begin bad++; $display("FAIL reset tx_tlast got=%b exp=0", tx_tlast); end
    total++; if (req_cnt !== '0) begin bad++; $display("FAIL reset req_cnt got=%0d exp=0", req_cnt); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL reset drop_cnt got=%0d exp=0", drop_cnt); end
    sys_rst_n = 1'b1;
    tick(2);
    exp_req = 0;
    exp_drop = 0;
    total++; if (rx_tready !== 1'b1) begin bad++; $display("FAIL post_reset rx_tready got=%b exp=1", rx_tready); end
  endtask

  task automatic test_valid_request();
    clear_q();
    tx_tready = 1'b1;
    make_req(48'haabbccddeeff, 32'hc0a80a02, LIP, 16'd1, 16'h0806, 42);
    build_reply(48'haabbccddeeff, 32'hc0a80a02);
    send_frame(1'b0);
    exp_req++;
    @(negedge clk156);
    total++; if (tx_tvalid !== 1'b1) begin bad++; $display("FAIL latency tx_tvalid got=%b exp=1", tx_tvalid); end
    total++; if (tx_tdata !== 64'h1100ffeeddccbbaa) begin bad++; $display("FAIL beat0 tx_tdata got=%h exp=1100ffeeddccbbaa", tx_tdata); end
    wait_beats(8);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (q_data.size() <= k || {q_data[k], q_keep[k], q_last[k]} !== {exp_word(k), exp_keep(k), k == 7}) begin
        bad++; $display("FAIL valid beat%0d got=%h/%h n=%0d exp=%h/%h", k, q_data[k], q_keep[k], q_data.size(), exp_word(k), exp_keep(k));
      end
    end
    tick(3);
    total++; if (q_data.size() != 8 || tx_tvalid !== 1'b0) begin bad++; $display("FAIL valid end beats=%0d tvalid=%b exp=8/0", q_data.size(), tx_tvalid); end
    total++; if (req_cnt !== CNT_W'(exp_req)) begin bad++; $display("FAIL valid req_cnt got=%0d exp=%0d", req_cnt, exp_req); end
    total++; if (drop_cnt !== CNT_W'(exp_drop)) begin bad++; $display("FAIL valid drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_padding();
    logic [47:0] smac;
    logic [31:0] sip;
    int          len;
    for (int it = 0; it < 6; it++) begin
      smac = (it < 2) ? 48'haabbccddeeff : 48'({$urandom, $urandom});
      sip  = (it < 2) ? 32'hc0a80a02 : $urandom;
      len  = (it == 0) ? 60 : (it == 1) ? 66 : int'($urandom_range(42, 72));
      clear_q();
      make_req(smac, sip, LIP, 16'd1, 16'h0806, len);
      build_reply(smac, sip);
      send_frame(1'b0);
      exp_req++;
      wait_beats(8);
      for (int k = 0; k < 8; k++) begin
        total++;
        if (q_data.size() <= k || {q_data[k], q_keep[k], q_last[k]} !== {exp_word(k), exp_keep(k), k == 7}) begin
          bad++; $display("FAIL pad len=%0d beat%0d got=%h/%h exp=%h/%h", len, k, q_data[k], q_keep[k], exp_word(k), exp_keep(k));
        end
      end
      tick(2);
      total++; if (req_cnt !== CNT_W'(exp_req)) begin bad++; $display("FAIL pad len=%0d req_cnt got=%0d exp=%0d", len, req_cnt, exp_req); end
    end
  endtask

  task automatic test_rejects();
    logic [31:0] tips [6] = '{32'hc0a80a09, LIP, LIP, LIP, LIP, LIP};
    logic [15:0] ops  [6] = '{16'd1, 16'd2, 16'd1, 16'd1, 16'd1, 16'd1};
    logic [15:0] prs  [6] = '{16'h0806, 16'h0806, 16'h0800, 16'h0806, 16'h0806, 16'h0806};
    int          lens [6] = '{42, 42, 42, 42, 40, 41};
    bit          bads [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 6; c++) begin
      clear_q();
      make_req(48'haabbccddeeff, 32'hc0a80a02, tips[c], ops[c], prs[c], lens[c]);
      send_frame(bads[c]);
      tick(12);
      total++; if (q_data.size() != 0) begin bad++; $display("FAIL reject case%0d beats got=%0d exp=0", c, q_data.size()); end
      total++; if (req_cnt !== CNT_W'(exp_req) || drop_cnt !== CNT_W'(exp_drop)) begin
        bad++; $display("FAIL reject case%0d cnt got=%0d/%0d exp=%0d/%0d", c, req_cnt, drop_cnt, exp_req, exp_drop);
      end
    end
  endtask

  task automatic test_random_mix();
    logic [47:0] smac;
    logic [31:0] sip, tip;
    logic [15:0] op, proto;
    bit          badf, qual;
    int          len;
    for (int it = 0; it < 10; it++) begin
      smac  = 48'({$urandom, $urandom});
      sip   = $urandom;
      tip   = ($urandom_range(0, 3) == 0) ? LIP + 32'd1 : LIP;
      op    = ($urandom_range(0, 3) == 0) ? 16'd2 : 16'd1;
      proto = ($urandom_range(0, 3) == 0) ? 16'h86dd : 16'h0806;
      badf  = ($urandom_range(0, 4) == 0);
      len   = int'($urandom_range(38, 72));
      qual  = (tip == LIP) && (op == 16'd1) && (proto == 16'h0806) && !badf && (len >= 42);
      clear_q();
      make_req(smac, sip, tip, op, proto, len);
      build_reply(smac, sip);
      send_frame(badf);
      if (qual) exp_req++;
      if (qual) wait_beats(8);
      tick(12);
      total++; if (q_data.size() != (qual ? 8 : 0)) begin bad++; $display("FAIL mix it%0d beats got=%0d exp=%0d", it, q_data.size(), qual ? 8 : 0); end
      for (int k = 0; k < q_data.size() && k < 8; k++) begin
        total++;
        if ({q_data[k], q_keep[k], q_last[k]} !== {exp_word(k), exp_keep(k), k == 7}) begin
          bad++; $display("FAIL mix it%0d beat%0d got=%h exp=%h", it, k, q_data[k], exp_word(k));
        end
      end
      total++; if (req_cnt !== CNT_W'(exp_req)) begin bad++; $display("FAIL mix it%0d req_cnt got=%0d exp=%0d", it, req_cnt, exp_req); end
    end
  endtask

  task automatic test_back_to_back();
    int ubase;
    clear_q();
    ubase = unstable;
    tx_tready = 1'b0;
    make_req(48'h0a0b0c0d0e0f, 32'hc0a80a21, LIP, 16'd1, 16'h0806, 42);
    build_reply(48'h0a0b0c0d0e0f, 32'hc0a80a21);
    send_frame(1'b0);
    tick(10);
    make_req(48'h101112131415, 32'hc0a80a22, LIP, 16'd1, 16'h0806, 60);
    send_frame(1'b0);
    exp_req += 2;
    exp_drop++;
    tick(5);
    total++; if (tx_tvalid !== 1'b1 || q_data.size() != 0) begin bad++; $display("FAIL b2b hold tvalid=%b beats=%0d exp=1/0", tx_tvalid, q_data.size()); end
    total++; if (tx_tdata !== exp_word(0)) begin bad++; $display("FAIL b2b held tdata got=%h exp=%h", tx_tdata, exp_word(0)); end
    total++; if (unstable != ubase) begin bad++; $display("FAIL b2b stable changes got=%0d exp=0", unstable - ubase); end
    total++; if (req_cnt !== CNT_W'(exp_req)) begin bad++; $display("FAIL b2b req_cnt got=%0d exp=%0d", req_cnt, exp_req); end
    total++; if (drop_cnt !== CNT_W'(exp_drop)) begin bad++; $display("FAIL b2b drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop); end
    tx_tready = 1'b1;
    wait_beats(8);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (q_data.size() <= k || {q_data[k], q_keep[k], q_last[k]} !== {exp_word(k), exp_keep(k), k == 7}) begin
        bad++; $display("FAIL b2b beat%0d got=%h exp=%h", k, q_data[k], exp_word(k));
      end
    end
    tick(20);
    total++; if (q_data.size() != 8) begin bad++; $display("FAIL b2b reply count beats got=%0d exp=8", q_data.size()); end
  endtask

  // A second tlast landing on the edge that accepts beat 7 is dropped;
  // one cycle later it is served.
  task automatic test_tx_boundary();
    for (int gap = 2; gap <= 3; gap++) begin
      clear_q();
      tx_tready = 1'b1;
      make_req(48'h020000000001, 32'hc0a80a31, LIP, 16'd1, 16'h0806, 42);
      build_reply(48'h020000000001, 32'hc0a80a31);
      send_frame(1'b0);
      tick(gap);
      make_req(48'h020000000002, 32'hc0a80a32, LIP, 16'd1, 16'h0806, 42);
      send_frame(1'b0);
      exp_req += 2;
      if (gap == 2) exp_drop++;
      tick(20);
      total++; if (q_data.size() != ((gap == 2) ? 8 : 16)) begin bad++; $display("FAIL edge gap%0d beats got=%0d exp=%0d", gap, q_data.size(), (gap == 2) ? 8 : 16); end
      total++; if (req_cnt !== CNT_W'(exp_req) || drop_cnt !== CNT_W'(exp_drop)) begin
        bad++; $display("FAIL edge gap%0d cnt got=%0d/%0d exp=%0d/%0d", gap, req_cnt, drop_cnt, exp_req, exp_drop);
      end
      for (int k = 0; k < 8; k++) begin
        total++;
        if (q_data.size() <= k || q_data[k] !== exp_word(k)) begin bad++; $display("FAIL edge gap%0d first beat%0d got=%h exp=%h", gap, k, q_data[k], exp_word(k)); end
      end
      if (gap == 3) begin
        build_reply(48'h020000000002, 32'hc0a80a32);
        for (int k = 0; k < 8; k++) begin
          total++;
          if (q_data.size() <= 8 + k || {q_data[8+k], q_keep[8+k], q_last[8+k]} !== {exp_word(k), exp_keep(k), k == 7}) begin
            bad++; $display("FAIL edge second beat%0d got=%h exp=%h", k, q_data[8+k], exp_word(k));
          end
        end
      end
    end
  endtask

  task automatic test_stall_random();
    logic [47:0] smac;
    logic [31:0] sip;
    int          ubase;
    for (int it = 0; it < 3; it++) begin
      clear_q();
      ubase = unstable;
      smac = 48'({$urandom, $urandom});
      sip  = $urandom;
      tx_tready = 1'b0;
      make_req(smac, sip, LIP, 16'd1, 16'h0806, 60);
      build_reply(smac, sip);
      send_frame(1'b0);
      exp_req++;
      for (int i = 0; i < 400 && q_data.size() < 8; i++) begin
        tx_tready = ($urandom_range(0, 1) == 1);
        tick(1);
      end
      tx_tready = 1'b1;
      tick(2);
      for (int k = 0; k < 8; k++) begin
        total++;
        if (q_data.size() <= k || {q_data[k], q_keep[k], q_last[k]} !== {exp_word(k), exp_keep(k), k == 7}) begin
          bad++; $display("FAIL stall it%0d beat%0d got=%h exp=%h", it, k, q_data[k], exp_word(k));
        end
      end
      total++; if (unstable != ubase) begin bad++; $display("FAIL stall it%0d stable changes got=%0d exp=0", it, unstable - ubase); end
    end
  endtask

  task automatic test_reset_mid_tx();
    clear_q();
    tx_tready = 1'b1;
    make_req(48'h0c0c0c0c0c0c, 32'hc0a80a41, LIP, 16'd1, 16'h0806, 42);
    send_frame(1'b0);
    for (int i = 0; i < 50 && q_data.size() < 3; i++) tick(1);
    sys_rst_n = 1'b0;
    #1;
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL midrst tx_tvalid got=%b exp=0", tx_tvalid); end
    total++; if (req_cnt !== '0 || drop_cnt !== '0) begin bad++; $display("FAIL midrst cnt got=%0d/%0d exp=0/0", req_cnt, drop_cnt); end
    tick(2);
    sys_rst_n = 1'b1;
    tick(2);
    exp_req = 0;
    exp_drop = 0;
    clear_q();
    make_req(48'h0d0d0d0d0d0d, 32'hc0a80a42, LIP, 16'd1, 16'h0806, 42);
    build_reply(48'h0d0d0d0d0d0d, 32'hc0a80a42);
    send_frame(1'b0);
    exp_req++;
    wait_beats(8);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (q_data.size() <= k || {q_data[k], q_keep[k], q_last[k]} !== {exp_word(k), exp_keep(k), k == 7}) begin
        bad++; $display("FAIL midrst fresh beat%0d got=%h exp=%h", k, q_data[k], exp_word(k));
      end
    end
    tick(2);
    total++; if (req_cnt !== CNT_W'(exp_req)) begin bad++; $display("FAIL midrst req_cnt got=%0d exp=%0d", req_cnt, exp_req); end
  endtask

  initial begin
    test_reset();
    test_valid_request();
    test_padding();
    test_rejects();
    test_random_mix();
    test_back_to_back();
    test_tx_boundary();
    test_stall_random();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arp_responder.md
Name: arp_responder

Overview:
Receive-side ARP stage on the 10G Ethernet path. It consumes a 64-bit AXI-Stream frame from the MAC RX, parses it into an arphdr, and qualifies it as an ARP request for this adapter's IP. It then builds an arphdr reply and serializes it as a 60-byte padded frame onto a MAC TX AXI-Stream. It sits between the MAC RX/TX and the shared arp_pkg definitions.

Parameters:
CNT_W, 16, width of the statistics counters (wrap-around, not saturating)

Ports:
clk156  in  1  core clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
local_mac  in  48  adapter MAC; quasi-static, sampled when a reply is built
local_ip  in  32  adapter IPv4; quasi-static
rx_tvalid  in  1  AXIS RX valid
rx_tready  out  1  AXIS RX ready
rx_tdata  in  64  RX data; byte 0 on the wire = tdata[7:0]
rx_tkeep  in  8  RX byte enables, contiguous from bit 0
rx_tlast  in  1  RX end of frame
rx_tuser  in  1  RX bad frame/FCS error, valid with tlast
tx_tvalid  out  1  AXIS TX valid
tx_tready  in  1  AXIS TX ready
tx_tdata  out  64  TX data, same byte order as RX
tx_tkeep  out  8  TX byte enables
tx_tlast  out  1  TX end of frame
req_cnt  out  CNT_W  accepted requests for local_ip
drop_cnt  out  CNT_W  qualified requests dropped because TX was busy

Behaviour:
- Reset (async assert, sync release): rx_tready=0 during reset, 1 afterwards. tx_tvalid=0, tx_tlast=0, tx_tdata=0, tx_tkeep=0, counters=0, RX FSM=IDLE, TX FSM=IDLE. Reset mid-frame abandons both RX capture and TX reply. The next RX beat after release is treated as beat 0.
- RX is always ready (rx_tready=1) and never back-pressures the MAC. A beat transfers on rx_tvalid&&rx_tready.
- RX FSM: IDLE -> CAPTURE on the first beat (beat 0). Beats 0..5 are stored into a 42-byte capture register at byte offset beat*8. Beat counter is 3 bits and stops counting at 6.
- CAPTURE -> IDLE on tlast. Frames longer than 6 beats (for example 60-byte padded frames) are accepted, and extra beats are ignored.
- Qualify on the tlast beat, as a single-cycle decision. All of the following must hold: tuser=0; total bytes >=42 (tlast at beat>=5, and if tlast at beat 5 then popcount(tkeep)>=2); h_proto=0x0806; ar_hrd=1; ar_pro=0x0800; ar_hln=6; ar_pln=4; ar_op=1; target_ip=local_ip. Multi-byte fields are big-endian on the wire.
- Frames failing any check are silently discarded with no counter change.
- Qualified request and TX IDLE: req_cnt+1. The reply is latched and the TX FSM enters SEND. tx_tvalid rises on the cycle after the RX tlast beat, so latency is 1 cycle.
- Qualified request and TX not IDLE: req_cnt+1 and drop_cnt+1, no reply. The in-flight reply is unaffected.
- Reply fields: h_dest=req sender_mac; h_source=local_mac; h_proto=0x0806; hrd=1; pro=0x0800; hln=6; pln=4; op=2; sender_mac=local_mac; sender_ip=local_ip; target_mac=req sender_mac; target_ip=req sender_ip; bytes 42..59 are zero.
- TX FSM: IDLE -> SEND, beats 0..7 of the 60-byte image. Beats 0..6 have tkeep=0xFF. Beat 7 has tkeep=0x0F and tlast=1.
- tx_tdata, tx_tkeep and tx_tlast are held stable while tx_tvalid && !tx_tready.
- On beat 7 accepted: return to IDLE and drop tx_tvalid the next cycle. A new qualified tlast arriving in that same cycle is dropped, because TX is not yet IDLE.
- tx_tready low indefinitely: TX waits with no timeout. RX keeps parsing and counts drops.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- arp_pkg additions: ETH_P_ARP=16'h0806, ARPHRD_ETHER=16'd1, ETH_P_IP=16'h0800, ARPOP_REQUEST=16'd1, ARPOP_REPLY=16'd2, ARP_FRAME_BYTES=42, ARP_TX_BYTES=60. Add a function converting a wire-order byte vector to/from arphdr; arphdr is MSB-first, so wire byte 0 = the struct's MSB byte.
- Sub-module arp_reply_tx: holds the 60-byte image and the TX FSM/beat counter, and handles AXIS TX. Its ports are load/busy plus the tx_* signals.

Test Plan:
- Common setup: local_mac=00:11:22:33:44:55, local_ip=c0a80a01.
- Valid request: 42-byte frame from aa:bb:cc:dd:ee:ff/c0a80a02, target c0a80a01, tx_tready=1 -> reply begins 1 cycle after RX tlast. Beat 0 tdata=0x1100ffeeddccbbaa, 8 beats, final tkeep=0x0F. op=2, tha=aa:..:ff, tpa=c0a80a02; req_cnt=1.
- Same request padded to 60 bytes, then to 66 bytes with tlast at beat 8 -> identical reply, req_cnt=2 and 3.
- Reject cases: target_ip=c0a80a09; op=2; h_proto=0x0800; tuser=1 on tlast; frame truncated to 40 bytes -> no tx_tvalid, counters unchanged.
- Back-to-back: tx_tready=0, two valid requests 10 cycles apart -> one reply held with stable data, drop_cnt=1, req_cnt=2. Releasing tready completes exactly one reply.
- Random tx_tready toggling during the reply -> the beat sequence is byte-identical to the no-stall case.
- sys_rst_n pulsed low at TX beat 3 -> tx_tvalid=0 immediately, counters=0. A following valid request produces a complete fresh reply.
